// File: rtl/buf_axis_tx_pkg.sv
// Shared defaults and types for the buffer-to-AXI-Stream drain block.
package buf_axis_tx_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_LENW   = 8;
  localparam int DEF_PKTW   = 16;

  // The only "state machine" is implied by the beat counter being zero or not.
  typedef enum logic {
    PH_IDLE   = 1'b0,
    PH_IN_PKT = 1'b1
  } phase_e;

endpackage

// File: rtl/buf_axis_tx.sv
// Pops words from the FIFO read port and frames them as an AXI4-Stream master
// with a single registered output stage and programmable packet length.
module buf_axis_tx
  import buf_axis_tx_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int LENW   = DEF_LENW,
  parameter int PKTW   = DEF_PKTW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [LENW-1:0]   pkt_len,
  input  logic              buf_isempty,
  input  logic [DWIDTH-1:0] buf_rdata,
  output logic              buf_re,
  output logic              m_tvalid,
  output logic [DWIDTH-1:0] m_tdata,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              busy,
  output logic [PKTW-1:0]   pkt_sent
);

  logic [LENW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [LENW-1:0]   len_q, len_d;
  logic              tvalid_q, tvalid_d;
  logic [DWIDTH-1:0] tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic [PKTW-1:0]   sent_q, sent_d;

  phase_e          phase;
  logic [LENW-1:0] eff_len;
  logic            last_beat;
  logic            load;
  logic            accept;

  assign phase  = (beat_cnt_q == '0) ? PH_IDLE : PH_IN_PKT;
  assign accept = tvalid_q && m_tready;

  // The stage may refill in the same cycle its beat is taken, giving 1 beat/cycle.
  assign load = enable && !buf_isempty && (!tvalid_q || m_tready);

  // Length is latched only at the first beat so mid-packet changes are ignored.
  assign eff_len   = (phase == PH_IDLE) ? ((pkt_len == '0) ? LENW'(1) : pkt_len) : len_q;
  assign last_beat = (beat_cnt_q == eff_len - LENW'(1));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    sent_d     = sent_q;

    if (accept && tlast_q)
      sent_d = sent_q + PKTW'(1);

    if (load) begin
      tvalid_d   = 1'b1;
      tdata_d    = buf_rdata;
      tlast_d    = last_beat;
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + LENW'(1);
      if (phase == PH_IDLE)
        len_d = eff_len;
    end else if (accept) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      len_q      <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      sent_q     <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      sent_q     <= sent_d;
    end
  end

  assign buf_re   = load;
  assign m_tvalid = tvalid_q;
  assign m_tdata  = tdata_q;
  assign m_tlast  = tlast_q;
  assign busy     = (phase == PH_IN_PKT) || tvalid_q;
  assign pkt_sent = sent_q;

endmodule

// File: tb/tb_buf_axis_tx.sv
// Bench for buf_axis_tx: modelled FIFO, directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based stream model.
module tb_buf_axis_tx;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int PW = 16;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [LW-1:0] pkt_len;
  logic          buf_isempty;
  logic [DW-1:0] buf_rdata;
  logic          buf_re;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tready;
  logic          busy;
  logic [PW-1:0] pkt_sent;

  buf_axis_tx #(.DWIDTH(DW), .LENW(LW), .PKTW(PW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pkt_len(pkt_len),
    .buf_isempty(buf_isempty), .buf_rdata(buf_rdata), .buf_re(buf_re),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tready(m_tready), .busy(busy), .pkt_sent(pkt_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO contents, beats owed to the consumer, packet position.
  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  logic [DW-1:0] fifo[$];
  beat_t         held[$];
  int            pos;
  int            mlen;
  logic [PW-1:0] msent;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    buf_isempty = (fifo.size() == 0);
    buf_rdata   = (fifo.size() != 0) ? fifo[0] : 32'hDEAD_BEEF;
  endtask

  // One clock: compare against the model, advance the model across the edge.
  task automatic cycle();
    bit     exp_re;
    int     plen;
    beat_t  b;
    drive();
    #1;
    chk("tvalid", m_tvalid, held.size() != 0);
    if (held.size() != 0) begin
      chk("tdata", m_tdata, held[0].d);
      chk("tlast", m_tlast, held[0].last);
    end
    exp_re = enable && (fifo.size() != 0) && ((held.size() == 0) || m_tready);
    chk("buf_re", buf_re, exp_re);
    chk("busy", busy, (pos != 0) || (held.size() != 0));
    chk("pkt_sent", pkt_sent, msent);
    if ((held.size() != 0) && m_tready) begin
      if (held[0].last) msent = msent + 1'b1;
      void'(held.pop_front());
    end
    if (exp_re) begin
      if (pos == 0) begin
        plen = int'(pkt_len);
        mlen = (plen == 0) ? 1 : plen;
      end
      b.d    = fifo.pop_front();
      b.last = (pos == mlen - 1);
      pos    = b.last ? 0 : pos + 1;
      held.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    fifo.delete();
    held.delete();
    pos   = 0;
    mlen  = 1;
    msent = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    drive();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    enable   = 1'b1;
    m_tready = 1'b1;
    n = 0;
    while ((fifo.size() != 0 || held.size() != 0) && n < 100) begin
      cycle();
      n++;
    end
    chk("drain_timeout", (fifo.size() != 0 || held.size() != 0), 1'b0);
  endtask

  typedef struct {
    bit            push;
    logic [DW-1:0] pdata;
    bit            en;
    bit            rdy;
    logic [LW-1:0] len;
    bit            e_re;
    bit            e_tv;
    logic [DW-1:0] e_td;
    bit            e_tl;
    bit            e_busy;
    logic [PW-1:0] e_sent;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // push pdata en rdy len | re tv tdata tlast busy sent
    vecs[0]  = '{1, 32'hA0, 1, 1, 2,  1, 0, 32'h00, 0, 0, 0};
    vecs[1]  = '{1, 32'hA1, 1, 0, 2,  0, 1, 32'hA0, 0, 1, 0};
    vecs[2]  = '{0, 32'h00, 1, 0, 2,  0, 1, 32'hA0, 0, 1, 0};
    vecs[3]  = '{0, 32'h00, 1, 1, 2,  1, 1, 32'hA0, 0, 1, 0};
    vecs[4]  = '{1, 32'hA2, 1, 1, 3,  1, 1, 32'hA1, 1, 1, 0};
    vecs[5]  = '{0, 32'h00, 1, 1, 3,  0, 1, 32'hA2, 0, 1, 1};
    vecs[6]  = '{1, 32'hA3, 0, 1, 3,  0, 0, 32'hA2, 0, 1, 1};
    vecs[7]  = '{0, 32'h00, 1, 0, 3,  1, 0, 32'hA2, 0, 1, 1};
    vecs[8]  = '{1, 32'hA4, 1, 0, 3,  0, 1, 32'hA3, 0, 1, 1};
    vecs[9]  = '{0, 32'h00, 1, 1, 3,  1, 1, 32'hA3, 0, 1, 1};
    vecs[10] = '{0, 32'h00, 1, 1, 0,  0, 1, 32'hA4, 1, 1, 1};
    vecs[11] = '{1, 32'hA5, 1, 1, 0,  1, 0, 32'hA4, 1, 0, 2};
    vecs[12] = '{1, 32'hA6, 1, 1, 0,  1, 1, 32'hA5, 1, 1, 2};
    vecs[13] = '{0, 32'h00, 1, 1, 0,  0, 1, 32'hA6, 1, 1, 3};
    vecs[14] = '{0, 32'h00, 1, 1, 0,  0, 0, 32'hA6, 1, 0, 4};

    rst      = 1'b1;
    enable   = 1'b1;
    m_tready = 1'b1;
    pkt_len  = 8'd4;
    model_clear();
    drive();
    @(negedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tdata", m_tdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sent", pkt_sent, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with an empty buffer.
    for (int i = 0; i < 20; i++) cycle();

    // Directed vector table.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      enable   = vecs[i].en;
      m_tready = vecs[i].rdy;
      pkt_len  = vecs[i].len;
      if (vecs[i].push) fifo.push_back(vecs[i].pdata);
      drive();
      #1;
      chk($sformatf("vec%0d_re", i), buf_re, vecs[i].e_re);
      chk($sformatf("vec%0d_tvalid", i), m_tvalid, vecs[i].e_tv);
      chk($sformatf("vec%0d_tdata", i), m_tdata, vecs[i].e_td);
      chk($sformatf("vec%0d_tlast", i), m_tlast, vecs[i].e_tl);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_sent", i), pkt_sent, vecs[i].e_sent);
      cycle();
    end

    // pkt_len=4, eight words back to back; first valid one cycle after push.
    do_reset();
    pkt_len = 8'd4;
    for (int i = 0; i < 8; i++) fifo.push_back(32'h10 + i);
    cycle();
    drive();
    #1;
    chk("first_valid_latency", {m_tvalid, m_tdata}, {1'b1, 32'h10});
    drain();
    chk("len4_sent", pkt_sent, 16'd2);

    // Backpressure: ready pattern 1,0,0,1,...
    do_reset();
    pkt_len = 8'd3;
    for (int i = 0; i < 9; i++) fifo.push_back(32'h200 + i);
    for (int i = 0; i < 40 && (fifo.size() != 0 || held.size() != 0); i++) begin
      m_tready = ((i % 3) == 0);
      cycle();
    end
    drain();
    chk("bp_sent", pkt_sent, 16'd3);

    // Underflow mid-packet: the packet resumes, no early tlast.
    do_reset();
    pkt_len = 8'd5;
    fifo.push_back(32'h300);
    fifo.push_back(32'h301);
    for (int i = 0; i < 10; i++) cycle();
    chk("gap_busy", busy, 1'b1);
    chk("gap_sent", pkt_sent, 16'd0);
    for (int i = 0; i < 3; i++) fifo.push_back(32'h302 + i);
    drain();
    chk("underflow_sent", pkt_sent, 16'd1);

    // pkt_len=0: every beat is last.
    do_reset();
    pkt_len = 8'd0;
    for (int i = 0; i < 3; i++) fifo.push_back(32'h400 + i);
    drain();
    chk("len0_sent", pkt_sent, 16'd3);

    // pkt_len 4 -> 2 while loading beat 2: packets of 4, 2, 2.
    do_reset();
    pkt_len = 8'd4;
    for (int i = 0; i < 8; i++) fifo.push_back(32'h500 + i);
    cycle();
    cycle();
    pkt_len = 8'd2;
    drain();
    chk("lenchg_sent", pkt_sent, 16'd3);

    // Asynchronous reset mid-packet.
    do_reset();
    pkt_len = 8'd4;
    for (int i = 0; i < 4; i++) fifo.push_back(32'h600 + i);
    m_tready = 1'b0;
    cycle();
    cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tvalid", m_tvalid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_tdata", m_tdata, 32'h0);
    model_clear();
    @(negedge clk);
    rst      = 1'b0;
    m_tready = 1'b1;
    pkt_len  = 8'd2;
    for (int i = 0; i < 4; i++) fifo.push_back(32'h700 + i);
    drain();
    chk("arst_after_sent", pkt_sent, 16'd2);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      enable   = ($urandom_range(9) != 0);
      m_tready = ($urandom_range(9) < 7);
      if ($urandom_range(9) == 0) pkt_len = LW'($urandom_range(5));
      if ($urandom_range(1) == 1) fifo.push_back($urandom);
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
